mult_booth: RTL and testbench
=============================

# mult_booth

Sequential radix-2 Booth multiplier for `mult` (and optionally `multu`). It sits upstream of the HI/LO select muxes in the multi-cycle CPU. It takes the A and B register outputs and produces the 64-bit product as `hi_out`/`lo_out`, which feed the `MultCtrl` inputs of the HI and LO muxes. The control FSM pulses `start` and stalls until `done`, then asserts `WriteHI`/`WriteLO`.

## Interface
Parameters:
- `WIDTH`, 32: operand width. The product is 2·WIDTH, split into hi/lo halves.

Ports:
- `clock`: in, 1. The single system clock; all state changes on its rising edge.
- `reset`: in, 1. Asynchronous, active-low.
- `start`: in, 1. Begin a multiply; sampled only in IDLE.
- `op_a`: in, WIDTH. Multiplicand (M); from RegAOut.
- `op_b`: in, WIDTH. Multiplier (Q); from RegBOut.
- `is_unsigned`: in, 1. Present only with `MULT_BOOTH_MULTU_EN`.
- `busy`: out, 1. High in RUN.
- `done`: out, 1. One-cycle pulse in DONE; `hi_out`/`lo_out` are valid.
- `hi_out`: out, WIDTH. Product bits [2W-1:W]; held until the next completion.
- `lo_out`: out, WIDTH. Product bits [W-1:0]; held until the next completion.

## Operation
- FSM states: IDLE → RUN → DONE → IDLE.
- IDLE:
  - `start`=1 latches `op_a` into M and `op_b` into Q.
  - Clears accumulator Acc (WIDTH+1 bits), Q₋₁=0 and step counter=0.
  - Goes to RUN.
  - `start`=0: stay in IDLE.
- RUN, one Booth step per cycle, decided on {Q[0],Q₋₁}:
  - 01: Acc += M.
  - 10: Acc −= M.
  - 00 or 11: no add.
  - Then arithmetic right shift of {Acc,Q,Q₋₁} by 1.
  - Acc is WIDTH+1 bits with M sign-extended, so M = −2^(W−1) cannot overflow.
  - Counter increments. After step `STEPS`: load `hi_out`=Acc[W-1:0] and `lo_out`=Q, then go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` in RUN or DONE is ignored. There is no queueing, and the latched operands are not disturbed.
- `op_a`/`op_b` may change freely after the start edge.
- `hi_out`/`lo_out` change only on the RUN→DONE edge. They are stable through later IDLE cycles.
- Reset asserted in any state, including mid-RUN:
  - Forces IDLE immediately.
  - Clears Acc, Q, M, counter, `hi_out` and `lo_out`.
  - The partial result is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `hi_out`=0, `lo_out`=0, state IDLE.
- Start edge E0 → RUN. Steps occur on edges E1…E`STEPS`. Edge E`STEPS` loads the outputs and enters DONE.
- `done` is high in the cycle after E`STEPS`. It falls at E`STEPS`+1.
- `busy` is high from after E0 through E`STEPS`.
- `STEPS`=WIDTH (32) by default, so `done` is visible 32 cycles after the start edge.
- A new `start` is accepted at the earliest in the IDLE cycle following DONE, giving back-to-back throughput of one op per `STEPS`+2 cycles.

## Configuration
- `MULT_BOOTH_MULTU_EN` defined:
  - Adds the `is_unsigned` port.
  - Operands are extended to WIDTH+1 bits: zero-extended if `is_unsigned`=1, sign-extended otherwise.
  - Acc becomes WIDTH+2 bits; `STEPS`=WIDTH+1 (33) for every op, signed or unsigned, so latency is uniform.
  - The product is taken from the low 2·WIDTH bits.
- Not defined: signed-only, `STEPS`=WIDTH, no `is_unsigned` port.

## Structure
- Shared package `cpu_pkg`:
  - `mult_state_t` enum (IDLE, RUN, DONE).
  - Constant `MULT_WIDTH`=32.
- `STEPS` is a localparam derived from the macro.
- One natural combinational sub-module, `booth_step`:
  - Inputs: {Acc,Q,Q₋₁} and M.
  - Output: the shifted next value.
  - The top holds the FSM, counter and output registers.

## Test plan
- `op_a`=3, `op_b`=4, start → after 32 cycles `done`=1, `hi_out`=0x00000000, `lo_out`=0x0000000C.
- `op_a`=7, `op_b`=0xFFFFFFFD (−3) → `hi_out`=0xFFFFFFFF, `lo_out`=0xFFFFFFEB. Also `op_a`=`op_b`=0xFFFFFFFF → hi=0, lo=1.
- `op_a`=`op_b`=0x80000000 → `hi_out`=0x40000000, `lo_out`=0x00000000 (checks the Acc overflow guard).
- Start 5×6. Pulse `start` with 9×9 at cycle 10 → result is 30, and `done` pulses exactly once. Then start 9×9 on the first IDLE cycle → 81 is accepted.
- Start a multiply, assert `reset` low at cycle 15 → `busy`, `done`, `hi_out`, `lo_out` are all 0 immediately. After release, a new 2×2 → 4.
- With `MULT_BOOTH_MULTU_EN`, `is_unsigned`=1, 0xFFFFFFFF×0xFFFFFFFF → after 33 cycles hi=0xFFFFFFFE, lo=0x00000001. Same operands with `is_unsigned`=0 → hi=0, lo=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: multiplier FSM state encoding and the datapath width.
package cpu_pkg;

  localparam int MULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: conditional add/subtract of M into Acc, then an
// arithmetic right shift of {Acc,Q,Q-1}. Packed layout is {acc[EW:0], q[EW-1:0], q_m1}.
module booth_step
  import cpu_pkg::*;
#(
  parameter int EW = MULT_WIDTH
) (
  input  logic [2*EW+1:0] cur,
  input  logic [EW-1:0]   m,
  output logic [2*EW+1:0] nxt
);

  logic [EW:0]   acc;
  logic [EW-1:0] q;
  logic          q_m1;
  logic [EW:0]   m_x;
  logic [EW:0]   sum;

  assign acc  = cur[2*EW+1:EW+1];
  assign q    = cur[EW:1];
  assign q_m1 = cur[0];
  // one guard bit keeps -2^(EW-1) representable after negation
  assign m_x  = {m[EW-1], m};

  always_comb begin
    sum = acc;
    case ({q[0], q_m1})
      2'b01:   sum = acc + m_x;
      2'b10:   sum = acc - m_x;
      default: sum = acc;
    endcase
    nxt = {sum[EW], sum, q};
  end

endmodule

// File: rtl/mult_booth.sv
// Sequential radix-2 Booth multiplier, one step per clock.
// Define MULT_BOOTH_MULTU_EN to add the is_unsigned port (operands widened by one bit).
//
// state | meaning
// IDLE  | waiting for start; operands latched on the start edge
// RUN   | one Booth step per cycle, busy=1
// DONE  | done=1 for one cycle, hi_out/lo_out valid
module mult_booth
  import cpu_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef MULT_BOOTH_MULTU_EN
  input  logic             is_unsigned,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

`ifdef MULT_BOOTH_MULTU_EN
  localparam int EW = WIDTH + 1;
`else
  localparam int EW = WIDTH;
`endif
  localparam int STEPS = EW;
  localparam int CW    = $clog2(STEPS + 1);

  mult_state_t state, state_nxt;

  logic [EW:0]       acc;
  logic [EW-1:0]     q;
  logic              q_m1;
  logic [EW-1:0]     m;
  logic [CW-1:0]     cnt;
  logic [EW-1:0]     m_in;
  logic [EW-1:0]     q_in;
  logic [2*EW+1:0]   step_nxt;
  logic [EW:0]       step_acc;
  logic [EW-1:0]     step_q;
  logic              step_q_m1;
  logic              last_step;
  logic [WIDTH-1:0]  hi_nxt;
  logic [WIDTH-1:0]  lo_nxt;

`ifdef MULT_BOOTH_MULTU_EN
  assign m_in = {~is_unsigned & op_a[WIDTH-1], op_a};
  assign q_in = {~is_unsigned & op_b[WIDTH-1], op_b};
`else
  assign m_in = op_a;
  assign q_in = op_b;
`endif

  booth_step #(.EW(EW)) u_step (
    .cur (({acc, q, q_m1})),
    .m   (m),
    .nxt (step_nxt)
  );

  assign {step_acc, step_q, step_q_m1} = step_nxt;
  assign last_step = (cnt == CW'(STEPS - 1));

  // product is {acc[EW-1:0], q}; only its low 2*WIDTH bits are reported
`ifdef MULT_BOOTH_MULTU_EN
  assign hi_nxt = {step_acc[WIDTH-2:0], step_q[WIDTH]};
  assign lo_nxt = step_q[WIDTH-1:0];
`else
  assign hi_nxt = step_acc[WIDTH-1:0];
  assign lo_nxt = step_q;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      q      <= '0;
      q_m1   <= 1'b0;
      m      <= '0;
      cnt    <= '0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m    <= m_in;
            q    <= q_in;
            acc  <= '0;
            q_m1 <= 1'b0;
            cnt  <= '0;
          end
        end
        RUN: begin
          acc  <= step_acc;
          q    <= step_q;
          q_m1 <= step_q_m1;
          cnt  <= cnt + CW'(1);
          if (last_step) begin
            hi_out <= hi_nxt;
            lo_out <= lo_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_booth.sv
// Self-checking bench for mult_booth: cycle-level behavioural model plus literal result checks.
module tb_mult_booth;
  import cpu_pkg::*;

`ifdef MULT_BOOTH_MULTU_EN
  localparam int STEPS = 33;
`else
  localparam int STEPS = 32;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] op_a  = '0;
  logic [31:0] op_b  = '0;
  logic        uns_sel = 1'b0;
  logic        busy, done;
  logic [31:0] hi_out, lo_out;

  int vectors = 0;
  int miscompares = 0;

  mult_booth #(.WIDTH(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op_a        (op_a),
    .op_b        (op_b),
`ifdef MULT_BOOTH_MULTU_EN
    .is_unsigned (uns_sel),
`endif
    .busy        (busy),
    .done        (done),
    .hi_out      (hi_out),
    .lo_out      (lo_out)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] ref_prod(logic [31:0] a, logic [31:0] b, logic u);
    longint          sa, sb;
    longint unsigned ua, ub;
`ifdef MULT_BOOTH_MULTU_EN
    if (u) begin
      ua = {32'd0, a};
      ub = {32'd0, b};
      return 64'(ua * ub);
    end
`endif
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  // Behavioural model: an accepted start yields its product exactly STEPS edges later.
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_pend = '0;
  int          m_left = 0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_hi <= '0; m_lo <= '0; m_left <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_hi   <= m_pend[63:32];
        m_lo   <= m_pend[31:0];
      end
    end else if (start) begin
      m_busy <= 1'b1;
      m_left <= STEPS;
      m_pend <= ref_prod(op_a, op_b, uns_sel);
    end
  end

  always @(negedge clock) begin
    vectors++;
    if ({busy, done, hi_out, lo_out} !== {m_busy, m_done, m_hi, m_lo}) begin
      miscompares++;
      $display("FAIL cycle t=%0t: dut busy=%b done=%b hi=%h lo=%h, model busy=%b done=%b hi=%h lo=%h",
               $time, busy, done, hi_out, lo_out, m_busy, m_done, m_hi, m_lo);
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_done(string name);
    bit seen = 0;
    for (int i = 0; i < STEPS + 8; i++) begin
      @(negedge clock);
      if (done) begin seen = 1; break; end
    end
    if (!seen) begin
      miscompares++;
      $display("FAIL %s: timeout waiting for done", name);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the first IDLE negedge after DONE.
  task automatic run_op(string name, logic [31:0] a, logic [31:0] b, logic u,
                        bit lit, logic [31:0] ehi, logic [31:0] elo);
    op_a = a; op_b = b; uns_sel = u; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    op_a = $urandom; op_b = $urandom;
    wait_done(name);
    if (lit) begin
      chk({name, " hi"}, hi_out, ehi);
      chk({name, " lo"}, lo_out, elo);
    end
    @(negedge clock);
  endtask

  logic [31:0] ra, rb;
  int          done_cnt;

  initial begin
    #1 reset = 1'b0;
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset hi", hi_out, 32'd0);
    chk("reset lo", lo_out, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    run_op("3x4", 32'd3, 32'd4, 1'b0, 1, 32'h0, 32'hC);
    run_op("7x-3", 32'd7, 32'hFFFF_FFFD, 1'b0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("-1x-1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1, 32'h0, 32'h1);
    run_op("minxmin", 32'h8000_0000, 32'h8000_0000, 1'b0, 1, 32'h4000_0000, 32'h0);

    // start pulsed mid-run must be ignored
    op_a = 32'd5; op_b = 32'd6; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    done_cnt = 0;
    repeat (9) @(negedge clock);
    op_a = 32'd9; op_b = 32'd9; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < STEPS + 8; i++) begin
      if (done) begin
        done_cnt++;
        chk("5x6 hi", hi_out, 32'd0);
        chk("5x6 lo", lo_out, 32'd30);
      end
      @(negedge clock);
    end
    chk("5x6 done pulses", 32'(done_cnt), 32'd1);

    // back-to-back: second start lands on the first IDLE cycle after DONE
    run_op("9x9 a", 32'd9, 32'd9, 1'b0, 1, 32'h0, 32'd81);
    run_op("9x9 b", 32'd9, 32'd9, 1'b0, 1, 32'h0, 32'd81);

    // reset mid-run
    op_a = 32'd1234; op_b = 32'd5678; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (14) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst hi", hi_out, 32'd0);
    chk("midrst lo", lo_out, 32'd0);
    @(negedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    run_op("2x2", 32'd2, 32'd2, 1'b0, 1, 32'h0, 32'd4);

`ifdef MULT_BOOTH_MULTU_EN
    run_op("u -1x-1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1, 32'hFFFF_FFFE, 32'h1);
    run_op("s -1x-1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1, 32'h0, 32'h1);
`endif

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom;
      case (i % 5)
        0: ra = 32'h8000_0000;
        1: rb = 32'h7FFF_FFFF;
        2: rb = 32'h0;
        default: ;
      endcase
`ifdef MULT_BOOTH_MULTU_EN
      run_op("rand", ra, rb, 1'($urandom_range(0, 1)), 0, 32'h0, 32'h0);
`else
      run_op("rand", ra, rb, 1'b0, 0, 32'h0, 32'h0);
`endif
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
